mux_two_to_one: RTL and testbench

Parameterised 2:1 data selector used on RISC datapath operand and write-back paths. It forwards `in_one` when `in_select` is 0 and `in_two` when `in_select` is 1. A synchronous housekeeping section counts select transitions for debug. A compile-time option retimes the data path through an output register.

---
 rtl/mux_two_to_one.sv | 65 ++++++
 tb/tb_mux_two_to_one.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_two_to_one.sv
// mux_two_to_one: parameterised 2:1 data selector for operand and write-back
// paths, with a saturating select-transition counter for debug.
// Optional build macro MUX_TWO_TO_ONE_REGISTERED_OUTPUT_EN: when defined,
// ou_result is retimed through a WIDTH-bit output register (1-cycle latency).
`timescale 1ns/1ps

module mux_two_to_one #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic [WIDTH-1:0] in_one,
   input  logic [WIDTH-1:0] in_two,
   input  logic             in_select,
   output logic [WIDTH-1:0] ou_result,
   output logic [CNT_W-1:0] ou_switch_count,
   output logic             ou_sel_q
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] select_c;
   logic [CNT_W-1:0] count_q;
   logic             sel_q;

   // Bitwise selection; an unknown select merges equal bits and leaves the rest X.
   always_comb begin
      select_c = in_select ? in_two : in_one;
   end

   // Select history and saturating transition counter; reset wins over counting.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         count_q <= '0;
         sel_q   <= 1'b0;
      end else begin
         sel_q <= in_select;
         if ((in_select != sel_q) && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   assign ou_switch_count = count_q;
   assign ou_sel_q        = sel_q;

`ifdef MUX_TWO_TO_ONE_REGISTERED_OUTPUT_EN
   logic [WIDTH-1:0] result_q;

   // Retimed data path: load the selected value on every edge.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         result_q <= '0;
      end else begin
         result_q <= select_c;
      end
   end

   assign ou_result = result_q;
`else
   assign ou_result = select_c;
`endif

endmodule

// File: tb/tb_mux_two_to_one.sv
// Self-checking bench for mux_two_to_one: vector table, hand-written counter and
// latency sequences, and randomized stimulus against a behavioural model.
`timescale 1ns/1ps

module tb_mux_two_to_one;

   localparam int CNT1_MAX = 3;    // CNT_W = 2
   localparam int CNT8_MAX = 255;  // CNT_W = 8

   logic       clk = 1'b0;
   logic       rst;

   // Narrow instance: WIDTH=1, CNT_W=2
   logic       one1, two1, sel1, res1, q1;
   logic [1:0] cnt1;

   // Wide instance: WIDTH=8, CNT_W=8
   logic [7:0] one8, two8, res8, cnt8;
   logic       sel8, q8;

   int checks   = 0;
   int failures = 0;

   // Behavioural reference state
   int         m_cnt1, m_cnt8;
   logic       m_q1, m_q8, m_r1;
   logic [7:0] m_r8;

   typedef struct {
      logic one;
      logic two;
      logic sel;
      logic exp;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   mux_two_to_one #(.WIDTH(1), .CNT_W(2)) dut1 (
      .in_clk(clk), .in_rst(rst), .in_one(one1), .in_two(two1),
      .in_select(sel1), .ou_result(res1), .ou_switch_count(cnt1), .ou_sel_q(q1)
   );

   mux_two_to_one #(.WIDTH(8), .CNT_W(8)) dut8 (
      .in_clk(clk), .in_rst(rst), .in_one(one8), .in_two(two8),
      .in_select(sel8), .ou_result(res8), .ou_switch_count(cnt8), .ou_sel_q(q8)
   );

   // Reference model: counts sampled select changes, saturating, and keeps
   // the value a retimed output would hold.
   always @(posedge clk) begin
      if (rst) begin
         m_cnt1 <= 0; m_cnt8 <= 0;
         m_q1   <= 1'b0; m_q8 <= 1'b0;
         m_r1   <= 1'b0; m_r8 <= 8'h00;
      end else begin
         if (sel1 != m_q1) m_cnt1 <= (m_cnt1 + 1 > CNT1_MAX) ? CNT1_MAX : m_cnt1 + 1;
         if (sel8 != m_q8) m_cnt8 <= (m_cnt8 + 1 > CNT8_MAX) ? CNT8_MAX : m_cnt8 + 1;
         m_q1 <= sel1;
         m_q8 <= sel8;
         m_r1 <= sel1 ? two1 : one1;
         m_r8 <= sel8 ? two8 : one8;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Current expected result given model state and present inputs
   function automatic logic exp_r1();
`ifdef MUX_TWO_TO_ONE_REGISTERED_OUTPUT_EN
      return m_r1;
`else
      return sel1 ? two1 : one1;
`endif
   endfunction

   function automatic logic [7:0] exp_r8();
`ifdef MUX_TWO_TO_ONE_REGISTERED_OUTPUT_EN
      return m_r8;
`else
      return sel8 ? two8 : one8;
`endif
   endfunction

   task automatic do_reset(input logic s1, input logic s8);
      @(negedge clk);
      rst = 1'b1; sel1 = s1; sel8 = s8;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      one1 = 1'b0; two1 = 1'b0; sel1 = 1'b0;
      one8 = 8'h00; two8 = 8'h00; sel8 = 1'b0;

      vecs[0] = '{one: 1'b0, two: 1'b0, sel: 1'b0, exp: 1'b0};
      vecs[1] = '{one: 1'b1, two: 1'b0, sel: 1'b0, exp: 1'b1};
      vecs[2] = '{one: 1'b0, two: 1'b1, sel: 1'b0, exp: 1'b0};
      vecs[3] = '{one: 1'b1, two: 1'b0, sel: 1'b1, exp: 1'b0};
      vecs[4] = '{one: 1'b1, two: 1'b1, sel: 1'b1, exp: 1'b1};

      // Reset: two edges with all inputs low
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_cnt1", 32'(cnt1), 32'd0);
      chk("reset_q1",   32'(q1),   32'd0);
      chk("reset_res1", 32'(res1), 32'd0);
      chk("reset_cnt8", 32'(cnt8), 32'd0);
      chk("reset_q8",   32'(q8),   32'd0);
      chk("reset_res8", 32'(res8), 32'd0);
      rst = 1'b0;

      // Vector table on the 1-bit instance, each checked 100 ns after apply
      for (int i = 0; i < 5; i++) begin
         one1 = vecs[i].one; two1 = vecs[i].two; sel1 = vecs[i].sel;
         repeat (10) @(negedge clk);
         chk($sformatf("vec%0d_res", i), 32'(res1), 32'(vecs[i].exp));
         chk($sformatf("vec%0d_cnt", i), 32'(cnt1), 32'(m_cnt1));
      end

      // Wide data
      one8 = 8'hA5; two8 = 8'h3C; sel8 = 1'b0;
      repeat (10) @(negedge clk);
      chk("wide_sel0", 32'(res8), 32'h0000_00A5);
      sel8 = 1'b1;
      repeat (10) @(negedge clk);
      chk("wide_sel1", 32'(res8), 32'h0000_003C);

      // Counter: 5 toggles on the wide instance, saturation after 6 on CNT_W=2
      do_reset(1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         sel1 = ~sel1; sel8 = ~sel8;
         @(negedge clk);
         if (i == 5) chk("cnt8_after5", 32'(cnt8), 32'd5);
      end
      chk("cnt1_saturated", 32'(cnt1), 32'd3);
      chk("cnt8_after6",    32'(cnt8), 32'd6);
      chk("q8_after6",      32'(q8),   32'(sel8));
      repeat (3) @(negedge clk);
      chk("cnt1_hold", 32'(cnt1), 32'd3);
      chk("cnt8_hold", 32'(cnt8), 32'd6);

      // Select held high across reset: reset wins, then first edge counts once
      do_reset(1'b1, 1'b1);
      chk("rst_prio_cnt8", 32'(cnt8), 32'd0);
      chk("rst_prio_q8",   32'(q8),   32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rel_cnt8", 32'(cnt8), 32'd1);
      chk("rst_rel_q8",   32'(q8),   32'd1);
      chk("rst_rel_cnt1", 32'(cnt1), 32'd1);

      // Result latency on a select change 0->1 with one=1, two=0
      do_reset(1'b0, 1'b0);
      rst = 1'b0;
      one1 = 1'b1; two1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("lat_before", 32'(res1), 32'd1);
      sel1 = 1'b1;
      #1;
`ifdef MUX_TWO_TO_ONE_REGISTERED_OUTPUT_EN
      chk("lat_hold", 32'(res1), 32'd1);
      @(posedge clk);
      #1;
      chk("lat_after_edge", 32'(res1), 32'd0);
`else
      chk("lat_comb", 32'(res1), 32'd0);
`endif

      // Randomized stimulus against the reference model
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         rst  = ($urandom_range(0, 24) == 0);
         one1 = 1'($urandom); two1 = 1'($urandom); sel1 = 1'($urandom);
         one8 = 8'($urandom); two8 = 8'($urandom);
         sel8 = ($urandom_range(0, 3) == 0) ? ~sel8 : sel8;
         #1;
         chk("rnd_res1", 32'(res1), 32'(exp_r1()));
         chk("rnd_res8", 32'(res8), 32'(exp_r8()));
         chk("rnd_cnt1", 32'(cnt1), 32'(m_cnt1));
         chk("rnd_cnt8", 32'(cnt8), 32'(m_cnt8));
         chk("rnd_q1",   32'(q1),   32'(m_q1));
         chk("rnd_q8",   32'(q8),   32'(m_q8));
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
